muls_x3y3: RTL and testbench
============================

# muls_x3y3

Sequential signed 3×3-bit multiplier in an 8-in/8-out pad-frame wrapper. Clock, reset and both operands arrive on one 8-bit input bus. It produces a 6-bit two's-complement product, a sign flag and a one-cycle ready strobe on one 8-bit output bus. It is the top-level user block of the chip tile, alongside the standalone half-adder and full-adder test tops.

## Interface
- Parameters: none. Widths are fixed constants: X_WIDTH=3, Y_WIDTH=3, P_WIDTH=6.
- Power pins vccd1/vssd1 exist only in gate-level netlists and are not part of the RTL.
- `io_in` input 8: packed `{y[2:0], x[2:0], rst, clk}`.
  - bit0 = `clk`, the single clock; all logic is rising-edge triggered.
  - bit1 = `rst`: reset is synchronous and active-high.
  - bits4:2 = `x`, signed multiplicand.
  - bits7:5 = `y`, signed multiplier.
- `io_out` output 8:
  - bits5:0 = `p`, registered two's-complement product.
  - bit6 = `s`, registered product sign, always equal to p[5].
  - bit7 = `rdy`, registered result strobe.

## Operation
- Arithmetic: p = sext(x) × sext(y), exact in 6 bits. Range is −12 (3×−4) to +16 (−4×−4); no overflow case exists. A zero product gives s=0.
- FSM states:
  - LOAD: capture x, y into operand registers, clear the accumulator, set step counter=0 → RUN.
  - RUN: perform one shift-add (or radix-2 Booth) partial-product step per cycle, 3 steps total.
    - The final step applies the sign-weight correction for the negative MSB of y (subtract rather than add).
    - Counter reaches 2 → DONE.
  - DONE: write the accumulator to the p register and set s=p[5] and rdy=1 → LOAD.
- rdy is 1 for exactly one cycle per result. It is 0 in all other cycles.
- p and s hold their value until the next DONE.
- The block free-runs, producing one result every 5 cycles. Operands are re-sampled in every LOAD state.
- Changes on x/y outside the LOAD cycle are ignored for the current computation.
- Reset while rst=1 at a rising edge:
  - state←LOAD, accumulator, operand registers and counter←0.
  - p←0, s←0, rdy←0.
  - Reset asserted mid-RUN or in DONE aborts the computation; no rdy pulse is issued for it.
- Reset has priority over all state transitions.

## Timing
- Edge numbering: E0 is the first rising edge with rst=0 after reset.
  - E0: LOAD samples operands.
  - E1–E3: RUN steps.
  - E4: DONE registers the result. After E4, p, s and rdy=1 are visible.
  - E5: LOAD of the next operands, rdy←0.
- Latency is 4 cycles from operand sample to valid output. Throughput is 1 result per 5 cycles.
- All outputs come straight from flops; there is no combinational path from io_in to io_out.

## Structure
- Shared package holds:
  - width constants: X_WIDTH, Y_WIDTH, P_WIDTH.
  - io bit positions: I_CLK=0, I_RST=1, I_X=2, I_Y=5, O_P=0, O_SIGN=6, O_READY=7.
  - FSM state encoding.
- Sub-module `full_adder` (a, b, ci → s, co) is instantiated 6× as the ripple accumulator adder.
  - Subtract is implemented as invert-plus-carry-in.

## Test plan
- Reset: hold rst=1 for 2 cycles with any x/y → io_out=0x00; no rdy after release until the 4th edge.
- x=3'b100 (−4), y=3'b100 (−4) → on the rdy cycle p=6'b010000 (16), s=0, io_out=0x90.
- x=3 (011), y=−4 (100) → p=6'b110100 (−12), s=1, io_out=0xF4.
- x=−1 (111), y=1 (001) → p=6'b111111, s=1. Then x=0, y=−3 on the next LOAD → p=0, s=0, with rdy pulses exactly 5 cycles apart.
- Operand stability: x=2, y=3 sampled at LOAD, then change x/y every cycle during RUN → result is still p=6.
- Reset mid-RUN: assert rst for one edge at E2 → no rdy pulse, p=0. The next result appears 4 edges after rst deasserts.
- Exhaustive sweep: all 64 x/y pairs → p equals the signed product and s=p[5] for each.

Source files
------------

// File: rtl/muls_x3y3_pkg.sv
// Shared constants for the 3x3 signed sequential multiplier tile:
// operand/product widths, pad-frame bit positions and FSM encoding.
package muls_x3y3_pkg;

    localparam int X_WIDTH = 3;
    localparam int Y_WIDTH = 3;
    localparam int P_WIDTH = 6;

    localparam int I_CLK   = 0;
    localparam int I_RST   = 1;
    localparam int I_X     = 2;
    localparam int I_Y     = 5;
    localparam int O_P     = 0;
    localparam int O_SIGN  = 6;
    localparam int O_READY = 7;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [P_WIDTH-1:0] prod_t;

    // Sign-extend the multiplicand to the accumulator width.
    function automatic prod_t sext_x(input logic [X_WIDTH-1:0] v);
        return {{(P_WIDTH - X_WIDTH){v[X_WIDTH-1]}}, v};
    endfunction

endpackage

// File: rtl/muls_x3y3_full_adder.sv
// One-bit full adder; a chain of these forms the accumulator adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/muls_x3y3.sv
// Sequential signed 3x3 multiplier behind an 8-in/8-out pad frame.
// LOAD -> RUN x3 (shift-add, last step subtracts) -> DONE, one result per 5 cycles.
module muls_x3y3
    import muls_x3y3_pkg::*;
(
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic               clk;
    logic               srst;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;

    assign clk  = io_in[I_CLK];
    assign srst = io_in[I_RST];
    assign x    = io_in[I_X +: X_WIDTH];
    assign y    = io_in[I_Y +: Y_WIDTH];

    logic [1:0]         state_reg, state_next;
    logic [X_WIDTH-1:0] x_reg, x_next;
    logic [Y_WIDTH-1:0] y_reg, y_next;
    logic [P_WIDTH-1:0] acc_reg, acc_next;
    logic [1:0]         cnt_reg, cnt_next;
    logic [P_WIDTH-1:0] p_reg, p_next;
    logic               s_reg, s_next;
    logic               rdy_reg, rdy_next;

    logic               y_bit;
    logic               sub;
    logic [P_WIDTH-1:0] shifted;
    logic [P_WIDTH-1:0] addend;
    logic [P_WIDTH-1:0] b_vec;
    logic [P_WIDTH-1:0] sum;
    logic [P_WIDTH-1:0] carry;
    logic               msb_co_unused;

    // The MSB of y carries negative weight, so the last step subtracts.
    always_comb begin
        y_bit = 1'b0;
        case (cnt_reg)
            2'd0:    y_bit = y_reg[0];
            2'd1:    y_bit = y_reg[1];
            default: y_bit = y_reg[2];
        endcase
        sub     = (cnt_reg == 2'd2);
        shifted = sext_x(x_reg) << cnt_reg;
        addend  = y_bit ? shifted : '0;
        b_vec   = addend ^ {P_WIDTH{sub}};
    end

    assign carry[0] = sub;

    generate
        for (genvar gi = 0; gi < P_WIDTH; gi++) begin : g_fa
            if (gi == P_WIDTH - 1) begin : g_msb
                full_adder u_fa (
                    .a  (acc_reg[gi]),
                    .b  (b_vec[gi]),
                    .ci (carry[gi]),
                    .s  (sum[gi]),
                    .co (msb_co_unused)
                );
            end else begin : g_lsb
                full_adder u_fa (
                    .a  (acc_reg[gi]),
                    .b  (b_vec[gi]),
                    .ci (carry[gi]),
                    .s  (sum[gi]),
                    .co (carry[gi+1])
                );
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        p_next     = p_reg;
        s_next     = s_reg;
        rdy_next   = 1'b0;
        case (state_reg)
            ST_LOAD: begin
                x_next     = x;
                y_next     = y;
                acc_next   = '0;
                cnt_next   = 2'd0;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                acc_next = sum;
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == 2'd2) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                p_next     = acc_reg;
                s_next     = acc_reg[P_WIDTH-1];
                rdy_next   = 1'b1;
                state_next = ST_LOAD;
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_LOAD;
            x_reg     <= '0;
            y_reg     <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            p_reg     <= '0;
            s_reg     <= 1'b0;
            rdy_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            p_reg     <= p_next;
            s_reg     <= s_next;
            rdy_reg   <= rdy_next;
        end
    end

    assign io_out[O_P +: P_WIDTH] = p_reg;
    assign io_out[O_SIGN]         = s_reg;
    assign io_out[O_READY]        = rdy_reg;

endmodule

// File: tb/tb_muls_x3y3.sv
// Randomized self-checking bench for muls_x3y3 against a cycle-schedule
// model that computes the signed product with plain integer arithmetic.
module tb_muls_x3y3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] x   = 3'd0;
    logic [2:0] y   = 3'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    assign io_in = {y, x, rst, clk};

    muls_x3y3 dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int         n_vec    = 0;
    int         n_bad    = 0;
    int         phase    = 0;
    int         op_x     = 0;
    int         op_y     = 0;
    int         cyc      = 0;
    int         last_rdy = -1;
    logic [7:0] exp_out  = 8'h00;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: io_out got 0x%02h, want 0x%02h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // One clock: drive inputs, advance the model by one edge, compare.
    task automatic step(input logic [2:0] nx, input logic [2:0] ny, input logic nr);
        int                 prod;
        logic signed [2:0]  sx;
        logic signed [2:0]  sy;
        @(negedge clk);
        x   = nx;
        y   = ny;
        rst = nr;
        @(posedge clk);
        cyc++;
        if (nr) begin
            phase    = 0;
            exp_out  = 8'h00;
            last_rdy = -1;
        end else begin
            if (phase == 0) begin
                sx   = nx;
                sy   = ny;
                op_x = sx;
                op_y = sy;
            end
            if (phase == 4) begin
                prod    = op_x * op_y;
                exp_out = {1'b1, prod[5], prod[5:0]};
            end else begin
                exp_out[7] = 1'b0;
            end
            phase = (phase + 1) % 5;
        end
        #1;
        chk("cycle", io_out, exp_out);
        if (io_out[7] === 1'b1) begin
            if (last_rdy >= 0) chk("rdy_gap", 8'(cyc - last_rdy), 8'd5);
            last_rdy = cyc;
        end
        $display("cyc %0d x=%0d y=%0d rst=%0b io_out=0x%02h", cyc, nx, ny, nr, io_out);
    endtask

    // Full computation; operands scrambled after the LOAD cycle.
    task automatic run_op(input logic [2:0] ox, input logic [2:0] oy);
        step(ox, oy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(3'($urandom), 3'($urandom), 1'b0);
        end
    endtask

    initial begin
        step(3'($urandom), 3'($urandom), 1'b1);
        step(3'($urandom), 3'($urandom), 1'b1);
        chk("reset", io_out, 8'h00);

        run_op(3'b100, 3'b100);
        chk("m4_x_m4", io_out, 8'h90);
        run_op(3'b011, 3'b100);
        chk("3_x_m4", io_out, 8'hF4);
        run_op(3'b111, 3'b001);
        chk("m1_x_1", io_out, 8'hFF);
        run_op(3'b000, 3'b101);
        chk("0_x_m3", io_out, 8'h80);
        run_op(3'b010, 3'b011);
        chk("stable_2x3", io_out, 8'h86);

        step(3'b101, 3'b101, 1'b0);
        step(3'b101, 3'b101, 1'b0);
        step(3'b101, 3'b101, 1'b1);
        chk("abort", io_out, 8'h00);
        run_op(3'b001, 3'b001);
        chk("post_rst", io_out, 8'h81);

        for (int xi = 0; xi < 8; xi++) begin
            for (int yi = 0; yi < 8; yi++) begin
                run_op(3'(xi), 3'(yi));
            end
        end

        for (int k = 0; k < 30; k++) begin
            run_op(3'($urandom), 3'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
